// File: rtl/shift_exec_pipe.sv
// Purpose: two-stage valid/ready shift unit (SLL/SRL/SRA) with a completed-op counter.
// Latency: a request accepted at edge k shows out_valid=1 after edge k+1; one result per cycle.
// Backpressure: out_valid && !out_ready freezes both stages; up to 2 requests held, then in_ready=0.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     request handshake; in_op (00 SLL, 01 SRL, 11 SRA, 10 reserved),
//                         in_a operand, in_shamt shift amount
//   out_valid/out_ready   result handshake; out_result shifted value, out_err reserved-op flag
//   op_count              number of completed output handshakes (wraps)
module shift_exec_pipe #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [N-1:0]         in_a,
    input  logic [$clog2(N)-1:0] in_shamt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_result,
    output logic                 out_err,
    output logic [CNT_W-1:0]     op_count
);

    localparam int SW = $clog2(N);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    // Stage-1 request register
    logic           s1_valid_q, s1_valid_d;
    logic [1:0]     s1_op_q,    s1_op_d;
    logic [N-1:0]   s1_a_q,     s1_a_d;
    logic [SW-1:0]  s1_shamt_q, s1_shamt_d;

    // Stage-2 result register
    logic           s2_valid_q, s2_valid_d;
    logic [N-1:0]   s2_result_q, s2_result_d;
    logic           s2_err_q,   s2_err_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic           s2_en;
    logic           in_xfer;
    logic           out_xfer;
    logic [N-1:0]   shift_res;

    // Shifter operates on the stage-1 contents
    always_comb begin
        shift_res = '0;
        unique case (s1_op_q)
            OP_SLL:  shift_res = s1_a_q << s1_shamt_q;
            OP_SRL:  shift_res = s1_a_q >> s1_shamt_q;
            OP_SRA:  shift_res = $unsigned($signed(s1_a_q) >>> s1_shamt_q);
            OP_RSV:  shift_res = '0;
            default: shift_res = '0;
        endcase
    end

    always_comb begin
        // Stage 2 may load whenever it is empty or being drained this cycle.
        s2_en    = !s2_valid_q || out_ready;
        // Combinational path from out_ready to in_ready is deliberate: it lets a
        // full pipe accept a new request in the same cycle it drains a result.
        in_ready = !s1_valid_q || s2_en;
        in_xfer  = in_valid && in_ready;
        out_xfer = s2_valid_q && out_ready;

        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_shamt_d  = s1_shamt_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_err_d    = s2_err_q;
        cnt_d       = cnt_q;

        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            // On a bubble the result/err registers keep their stale contents.
            if (s1_valid_q) begin
                s2_result_d = shift_res;
                s2_err_d    = (s1_op_q == OP_RSV);
            end
        end

        // Stage 1 loads on any accepted request (including the stalled-but-empty
        // case), otherwise it empties once its contents move into stage 2.
        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_op_d    = in_op;
            s1_a_d     = in_a;
            s1_shamt_d = in_shamt;
        end else if (s2_en) begin
            s1_valid_d = 1'b0;
        end

        if (out_xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_shamt_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_err_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_shamt_q  <= s1_shamt_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_err_q    <= s2_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_err    = s2_err_q;
    assign op_count   = cnt_q;

endmodule
